// File: rtl/cbf_doa_peak_search_pkg.sv
// Shared types and helpers for the CBF DOA peak search.
// Also used by the steering-vector LUT for angle width.
package cbf_doa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUTPUT
  } state_t;

  localparam int DEF_WORD_LENGTH_POWER = 88;

  function automatic int angle_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cbf_doa_peak_search_if.sv
// Power input stream and peak result stream.
// master = upstream/sink side, slave = peak search.
interface cbf_doa_peak_search_if
  import cbf_doa_pkg::*;
#(
  parameter int DW = DEF_WORD_LENGTH_POWER,
  parameter int AW = 8
);

  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] m_axis_tdata;
  logic [DW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser,
    input  m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser,
    output m_axis_tvalid
  );

endinterface

// File: rtl/cbf_argmax_reg.sv
// Running maximum of captured power and its bin index.
// Strict compare keeps the lowest index on ties.
module cbf_argmax_reg #(
  parameter int WP = 88,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_upd,
  input  logic [WP-1:0] i_data,
  input  logic [AW-1:0] i_idx,
  output logic [WP-1:0] o_pow,
  output logic [AW-1:0] o_idx
);

  logic [WP-1:0] r_pow;
  logic [AW-1:0] r_idx;
  logic          w_gt;

  assign w_gt = i_data > r_pow;

  // clear at sweep start, load on bin 0, else keep the larger
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pow <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_pow <= '0;
      r_idx <= '0;
    end else if (i_load || (i_upd && w_gt)) begin
      r_pow <= i_data;
      r_idx <= i_idx;
    end
  end

  assign o_pow = r_pow;
  assign o_idx = r_idx;

endmodule

// File: rtl/cbf_doa_peak_search.sv
// Angle sweep controller: settle, capture, argmax, emit.
// Settling beats after each angle step are discarded.
module cbf_doa_peak_search
  import cbf_doa_pkg::*;
#(
  parameter int WORD_LENGTH_POWER = DEF_WORD_LENGTH_POWER,
  parameter int NUM_ANGLES        = 181,
  parameter int ANGLE_INDEX_WIDTH = angle_width(NUM_ANGLES),
  parameter int SETTLE_SAMPLES    = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic [ANGLE_INDEX_WIDTH-1:0] angle_idx,
  cbf_doa_peak_search_if.slave         bus
);

  localparam int AW = ANGLE_INDEX_WIDTH;
  localparam int WP = WORD_LENGTH_POWER;
  localparam int CW = $clog2(SETTLE_SAMPLES + 2);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_SAMPLES);
  localparam logic [AW-1:0] LAST = AW'(NUM_ANGLES - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_angle, w_angle_nxt;
  logic          r_rdy;
  logic          w_clr, w_load, w_upd;
  logic [WP-1:0] w_best_pow;
  logic [AW-1:0] w_best_idx;

  // state, settle counter and angle registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_angle <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_angle <= w_angle_nxt;
      r_rdy   <= 1'b1;
    end
  end

  // next-state and argmax control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_angle_nxt = r_angle;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_upd       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_angle_nxt = '0;
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (SETTLE_SAMPLES == 0) begin
          w_state_nxt = ST_CAPTURE;
        end else if (bus.s_axis_tvalid) begin
          if (r_cnt == SETTLE_C - CW'(1)) begin
            w_state_nxt = ST_CAPTURE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_CAPTURE: begin
        if (bus.s_axis_tvalid) begin
          w_load = (r_angle == '0);
          w_upd  = (r_angle != '0);
          if (r_angle == LAST) begin
            w_state_nxt = ST_OUTPUT;
          end else begin
            w_angle_nxt = r_angle + AW'(1);
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_OUTPUT: begin
        if (bus.m_axis_tready) begin
          w_state_nxt = ST_IDLE;
          w_angle_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  cbf_argmax_reg #(
    .WP (WP),
    .AW (AW)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_upd  (w_upd),
    .i_data (bus.s_axis_tdata),
    .i_idx  (r_angle),
    .o_pow  (w_best_pow),
    .o_idx  (w_best_idx)
  );

  assign busy              = (r_state != ST_IDLE);
  assign angle_idx         = r_angle;
  assign bus.s_axis_tready = r_rdy;
  assign bus.m_axis_tvalid = (r_state == ST_OUTPUT);
  assign bus.m_axis_tdata  = w_best_idx;
  assign bus.m_axis_tuser  = w_best_pow;

endmodule

// File: tb/tb_cbf_doa_peak_search.sv
// Directed and randomized sweeps for cbf_doa_peak_search.
// 4 angles, 2 settle beats, reference argmax model.
module tb_cbf_doa_peak_search;

  localparam int W  = 88;
  localparam int NA = 4;
  localparam int SS = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] angle_idx;

  int checks = 0;
  int errors = 0;

  cbf_doa_peak_search_if #(.DW(W), .AW(AW)) bus ();

  cbf_doa_peak_search #(
    .WORD_LENGTH_POWER (W),
    .NUM_ANGLES        (NA),
    .ANGLE_INDEX_WIDTH (AW),
    .SETTLE_SAMPLES    (SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .angle_idx (angle_idx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[W-1:0];
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // peak = largest value; index = first bin holding it
  function automatic void model(input logic [W-1:0] c [NA],
                                output int idx,
                                output logic [W-1:0] p);
    p = '0;
    for (int i = 0; i < NA; i++)
      if (c[i] > p) p = c[i];
    idx = -1;
    for (int i = NA - 1; i >= 0; i--)
      if (c[i] == p) idx = i;
  endfunction

  // gm: 0 back-to-back, 1 alternating valid, 2 random gaps
  task automatic sweep(input logic [W-1:0] c [NA], input int gm);
    int          ei;
    logic [W-1:0] ep;
    bit          last;
    model(c, ei, ep);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_go", 128'(busy), 128'(1));
    for (int a = 0; a < NA; a++) begin
      for (int b = 0; b <= SS; b++) begin
        last = (a == NA - 1) && (b == SS);
        check("angle", 128'(angle_idx), 128'(a));
        if (last)
          check("tv_pre", 128'(bus.m_axis_tvalid), 128'(0));
        bus.s_axis_tvalid = 1'b1;
        if (b == SS)      bus.s_axis_tdata = c[a];
        else if (gm == 2) bus.s_axis_tdata = rnd();
        else              bus.s_axis_tdata = W'(999);
        tick();
        if (!last && (gm == 1 || (gm == 2 && $urandom_range(0, 1) == 1))) begin
          bus.s_axis_tvalid = 1'b0;
          bus.s_axis_tdata  = rnd();
          tick();
        end
      end
    end
    bus.s_axis_tvalid = 1'b0;
    check("tv_rise", 128'(bus.m_axis_tvalid), 128'(1));
    check("res_idx", 128'(bus.m_axis_tdata), 128'(ei));
    check("res_pow", 128'(bus.m_axis_tuser), 128'(ep));
  endtask

  task automatic handshake();
    bus.m_axis_tready = 1'b1;
    tick();
    bus.m_axis_tready = 1'b0;
    check("hs_busy", 128'(busy), 128'(0));
    check("hs_tv", 128'(bus.m_axis_tvalid), 128'(0));
    check("hs_ang", 128'(angle_idx), 128'(0));
  endtask

  logic [W-1:0] cp [NA];
  int           xi;
  logic [W-1:0] xp;

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;

    // reset with random activity
    for (int i = 0; i < 4; i++) begin
      start             = 1'($urandom);
      bus.s_axis_tvalid = 1'($urandom);
      bus.s_axis_tdata  = rnd();
      bus.m_axis_tready = 1'($urandom);
      tick();
    end
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ang", 128'(angle_idx), 128'(0));
    check("rst_tv", 128'(bus.m_axis_tvalid), 128'(0));
    check("rst_td", 128'(bus.m_axis_tdata), 128'(0));
    check("rst_tu", 128'(bus.m_axis_tuser), 128'(0));
    check("rst_rdy", 128'(bus.s_axis_tready), 128'(0));
    start             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    tick();
    check("rel_rdy", 128'(bus.s_axis_tready), 128'(1));
    check("rel_busy", 128'(busy), 128'(0));

    // basic sweep
    cp = '{W'(10), W'(50), W'(30), W'(20)};
    sweep(cp, 0);
    handshake();

    // ties and all-zero
    cp = '{W'(40), W'(40), W'(10), W'(40)};
    sweep(cp, 0);
    handshake();
    cp = '{W'(0), W'(0), W'(0), W'(0)};
    sweep(cp, 0);
    handshake();

    // alternating valid gaps
    cp = '{W'(10), W'(50), W'(30), W'(20)};
    sweep(cp, 1);
    handshake();

    // backpressure: result held, start and beats ignored
    cp = '{W'(5), W'(7), W'(91), W'(91)};
    sweep(cp, 0);
    model(cp, xi, xp);
    for (int i = 0; i < 5; i++) begin
      start             = (i % 2 == 0);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rnd();
      tick();
      check("bp_tv", 128'(bus.m_axis_tvalid), 128'(1));
      check("bp_idx", 128'(bus.m_axis_tdata), 128'(xi));
      check("bp_pow", 128'(bus.m_axis_tuser), 128'(xp));
      check("bp_busy", 128'(busy), 128'(1));
    end
    start             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    handshake();

    // randomized sweeps, some with forced ties
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NA; i++)
        cp[i] = (s % 2 == 0) ? W'($urandom_range(0, 3)) : rnd();
      sweep(cp, 2);
      handshake();
    end

    // abort at angle 2
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && angle_idx != AW'(2); i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rnd();
      tick();
    end
    check("ab_at2", 128'(angle_idx), 128'(2));
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("ab_ang", 128'(angle_idx), 128'(0));
    check("ab_busy", 128'(busy), 128'(0));
    check("ab_tv", 128'(bus.m_axis_tvalid), 128'(0));
    bus.m_axis_tready = 1'b1;
    tick();
    tick();
    check("ab_tv2", 128'(bus.m_axis_tvalid), 128'(0));
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    tick();
    check("ab_rdy", 128'(bus.s_axis_tready), 128'(1));
    cp = '{W'(3), W'(2), W'(8), W'(100)};
    sweep(cp, 0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbf_doa_peak_search.md
# cbf_doa_peak_search

Sweep controller and argmax stage that sits directly downstream of the CBF power estimator in the ULA DOA chain. It steps an angle index through `NUM_ANGLES` bins; the steering-vector LUT maps that index to the estimator's `Is*/Qs*` inputs. For each bin it discards the estimator outputs that are still settling, captures one averaged power sample, and tracks the maximum. At the end of the sweep it emits the winning angle index and its power on an AXI-stream style output.

## Interface
- `WORD_LENGTH_POWER`, 88: width of the averaged power word from the estimator, unsigned.
- `NUM_ANGLES`, 181: number of steering bins per sweep, ≥2.
- `ANGLE_INDEX_WIDTH`, `$clog2(NUM_ANGLES)`: width of angle index.
- `SETTLE_SAMPLES`, 9: valid input beats discarded after each angle change. Must be ≥ estimator moving-average depth + steering LUT latency in beats.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle request to begin a sweep; ignored unless idle.
- `busy`  out  1  high from sweep start until the output handshake completes.
- `angle_idx`  out  ANGLE_INDEX_WIDTH  current steering bin, to the steering LUT.
- `s_axis_tdata`  in  WORD_LENGTH_POWER  averaged power from the estimator.
- `s_axis_tvalid`  in  1  power beat valid.
- `s_axis_tready`  out  1  constant 1 after reset; beats are dropped when not in use.
- `m_axis_tdata`  out  ANGLE_INDEX_WIDTH  index of the peak bin.
- `m_axis_tuser`  out  WORD_LENGTH_POWER  power at the peak bin.
- `m_axis_tvalid`  out  1  result valid.
- `m_axis_tready`  in  1  result accepted.

## Operation
- **States:** IDLE, SETTLE, CAPTURE, OUTPUT.
- **IDLE**
  - `angle_idx`=0, `busy`=0.
  - `start`=1 → SETTLE. Clear the settle counter and the best registers; `busy`=1 from the next cycle.
- **SETTLE**
  - Count only cycles with `s_axis_tvalid`=1; data is discarded.
  - When the count reaches `SETTLE_SAMPLES` → CAPTURE, and the counter clears.
  - If `SETTLE_SAMPLES`=0, go straight to CAPTURE.
- **CAPTURE**
  - Act on the first valid beat only.
  - At `angle_idx`=0, load best_power/best_idx unconditionally.
  - Otherwise update only if `s_axis_tdata` > best_power (strict unsigned compare), so ties keep the lowest index.
  - Same edge, if `angle_idx`=`NUM_ANGLES`-1 → OUTPUT. Otherwise increment `angle_idx` → SETTLE.
- **OUTPUT**
  - `m_axis_tvalid`=1; `m_axis_tdata`/`m_axis_tuser` = best_idx/best_power.
  - Output is held stable until `m_axis_tvalid`&`m_axis_tready`, then → IDLE and `angle_idx` returns to 0.
  - Input beats are dropped.
- `start` while `busy`=1 is ignored (no queueing).
- `angle_idx` never exceeds `NUM_ANGLES`-1; no wrap within a sweep.
- Comparator is full-width unsigned; no truncation or saturation.

## Timing
- **Reset values** (asynchronous on `rst`=0): state IDLE, `angle_idx`=0, `busy`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, counters/best=0. `s_axis_tready` is 0 during reset and 1 after.
- **Reset mid-sweep** aborts the sweep immediately; no partial result is emitted.
- **Sweep length:** exactly `NUM_ANGLES`×(`SETTLE_SAMPLES`+1) valid input beats.
- `m_axis_tvalid` rises the cycle after the edge that accepts the final capture beat.
- `angle_idx` changes on the edge that accepts a capture beat. The LUT/estimator latency is absorbed by SETTLE.
- **Throughput:** one input beat per cycle, no bubbles inserted; gaps in `s_axis_tvalid` only stall the counters.
- **Earliest restart:** `start` is accepted the cycle after the output handshake.

## Structure
- Package `cbf_doa_pkg` holds:
  - the state enum;
  - the default `WORD_LENGTH_POWER`;
  - a clog2-based angle-width helper, shared with the steering LUT.
- Sub-module `cbf_argmax_reg`: best_power/best_idx registers plus the compare, with load/update/clear controls. The FSM and counters stay in the top.

## Test plan
All scenarios use `NUM_ANGLES`=4, `SETTLE_SAMPLES`=2.
- **Reset:** hold `rst`=0 with random inputs → all outputs 0, `s_axis_tready`=0. Release → `s_axis_tready`=1, `busy`=0.
- **Basic sweep:** `start`, then 12 back-to-back beats whose capture beats (3rd, 6th, 9th, 12th) are 10, 50, 30, 20 and whose settle beats are 999 → output idx=1, power=50. `m_axis_tvalid` rises one cycle after beat 12; `angle_idx` sequence is 0,1,2,3.
- **Ties / all-zero:** captures 40, 40, 10, 40 → idx=0, power=40. All-zero captures → idx=0, power=0.
- **Valid gaps:** the basic sweep stimulus with `s_axis_tvalid` toggling 1010… → same result. Only valid beats are counted.
- **Backpressure:** hold `m_axis_tready`=0 for 5 cycles while pulsing `start` and driving input beats → output stable, `busy`=1, no new sweep. Raise `m_axis_tready` → handshake, IDLE, `busy`=0 next cycle.
- **Abort:** assert `rst`=0 while `angle_idx`=2 → immediate IDLE, `angle_idx`=0, no `m_axis_tvalid`. A new sweep afterwards gives a correct result.
